boxcar_seq_ctrl: RTL and testbench
==================================

Name: boxcar_seq_ctrl

Overview:
- Sequencer for a runtime-length boxcar (moving-sum) datapath: a delay-line RAM plus an accumulator computing acc += din - mem[rd_addr].
- Controls the following:
  - flushes the delay line to zero on start;
  - generates write/read pointers;
  - gates accumulation during warm-up;
  - issues decimated output-valid strobes.
- Sits between the ADC sample stream and the boxcar datapath; configured from the register bank.

Parameters:
ADDR_WIDTH, 4, delay-line address width; DEPTH = 2**ADDR_WIDTH.
DECIM_WIDTH, 8, width of the decimation-ratio input.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse; latches config and (re)starts the flush.
length  in  ADDR_WIDTH+1  window length N; 0 is treated as 1; values above DEPTH are clamped to DEPTH.
decim  in  DECIM_WIDTH  decimation ratio D; 0 is treated as 1.
din_valid  in  1  input sample present this cycle.
ram_we  out  1  delay-line write enable.
ram_wzero  out  1  selects 0 as the RAM write data (flush).
wr_addr  out  ADDR_WIDTH  delay-line write address.
rd_addr  out  ADDR_WIDTH  delay-line read address = wr_addr - N mod DEPTH.
acc_clear  out  1  synchronous clear of the datapath accumulator.
acc_en  out  1  accumulator update enable.
dout_valid  out  1  decimated output strobe.
busy  out  1  high in FLUSH and FILL.
state  out  2  current state: IDLE=0, FLUSH=1, FILL=2, RUN=3.

Behaviour:
- Reset values: state IDLE; wr_addr 0; rd_addr 0; all strobes 0; busy 0; latched N=1, D=1.
- start:
  - Accepted in any state, including mid-FLUSH, FILL or RUN.
  - Next cycle: state FLUSH, wr_addr 0, flush counter 0.
  - N and D are latched after clamping; later changes to length/decim are ignored until the next start.
- IDLE:
  - ram_we, acc_en and dout_valid stay 0; din_valid is ignored.
- FLUSH:
  - Runs exactly DEPTH cycles: ram_we=1, ram_wzero=1, wr_addr 0..DEPTH-1.
  - acc_clear=1 on the first FLUSH cycle only; acc_en=0.
  - din_valid is ignored (samples dropped); busy=1.
  - After the cycle with wr_addr=DEPTH-1: wr_addr wraps to 0 and state goes to FILL with fill_cnt=0.
- FILL / RUN, per din_valid cycle:
  - ram_we=1, ram_wzero=0, acc_en=1 (combinational with din_valid);
  - wr_addr increments modulo DEPTH at the clock edge.
  - rd_addr tracks wr_addr - N mod DEPTH at all times.
  - Flushed zeros make the subtracted term 0 during warm-up.
- FILL exit:
  - fill_cnt counts accepted samples.
  - On the Nth sample: state goes to RUN and the decimation counter loads 0.
  - That sample is the first full-window sample and is decimation-eligible.
- Decimation:
  - Counter runs over 0..D-1 on eligible samples (the Nth sample and every RUN sample).
  - When counter==0 at an eligible sample, dout_valid=1 in the following cycle (registered, 1-cycle latency, matching the datapath's registered output).
  - Counter wraps at D-1.
  - Result: first strobe after sample N, then one strobe every D samples.
- No din_valid: pointers, counters and state hold; all strobes are 0.
- N=DEPTH: rd_addr==wr_addr, so the read-before-write RAM returns the oldest sample.
- Simultaneous start and din_valid: start wins and the sample is dropped.
- RUN persists until start or rst; there is no automatic stop.

Optional Feature:
- Macro: BOXCAR_SEQ_CTRL_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt [15:0], counting din_valid cycles ignored in IDLE or FLUSH, or lost to a simultaneous start.
  - Saturates at 16'hFFFF; cleared by rst and by start (the start cycle's own dropped sample is counted after the clear).
- Undefined: no port and no counter logic.

Test Plan:
1. Reset: assert rst mid-RUN -> immediately state=0, wr_addr=0, ram_we=0, dout_valid=0, busy=0.
2. Flush: start with length=5, decim=1, din_valid held 1 -> 16 cycles of ram_we=1/ram_wzero=1 with wr_addr 0..15, acc_clear only on cycle 1, acc_en=0; then FILL.
3. Fill and run, N=5, D=1, continuous din_valid:
   - dout_valid first high the cycle after the 5th sample, then every cycle;
   - rd_addr = wr_addr - 5 mod 16 throughout.
4. Decimation, N=3, D=4, din_valid every other cycle: strobes after samples 3, 7, 11, 15; exactly one-cycle pulses.
5. Clamping and wrap:
   - length=0 -> N=1, first strobe after sample 1;
   - length=20 -> N=16, rd_addr==wr_addr;
   - 40 samples wrap wr_addr 15->0 cleanly.
6. Restart: start pulse mid-RUN coinciding with din_valid -> sample dropped, new FLUSH begins at wr_addr 0; with BOXCAR_SEQ_CTRL_DROP_CNT_EN defined, drop_cnt=1 after the start cycle.

Source files
------------

// File: rtl/boxcar_seq_ctrl.sv
// Sequencer for a runtime-length boxcar (moving-sum) datapath: flush, pointer generation,
// warm-up gating and decimated output strobes. Optional drop counter: BOXCAR_SEQ_CTRL_DROP_CNT_EN.
module boxcar_seq_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    length,
  input  logic [DECIM_WIDTH-1:0] decim,
  input  logic                   din_valid,
  output logic                   ram_we,
  output logic                   ram_wzero,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic                   acc_clear,
  output logic                   acc_en,
  output logic                   dout_valid,
  output logic                   busy,
  output logic [1:0]             state
`ifdef BOXCAR_SEQ_CTRL_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_FILL  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0]    DEPTH_N = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]    ONE_N   = 1;
  localparam logic [ADDR_WIDTH-1:0]  ONE_A   = 1;
  localparam logic [DECIM_WIDTH-1:0] ONE_D   = 1;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH:0]    fill_cnt_q, fill_cnt_d;
  logic [ADDR_WIDTH:0]    n_q, n_d;
  logic [DECIM_WIDTH-1:0] d_q, d_d;
  logic [DECIM_WIDTH-1:0] dec_cnt_q, dec_cnt_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   eligible;
  logic [DECIM_WIDTH-1:0] dec_base;

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    fill_cnt_d   = fill_cnt_q;
    n_d          = n_q;
    d_d          = d_q;
    dec_cnt_d    = dec_cnt_q;
    dout_valid_d = 1'b0;
    ram_we       = 1'b0;
    ram_wzero    = 1'b0;
    acc_clear    = 1'b0;
    acc_en       = 1'b0;
    eligible     = 1'b0;
    dec_base     = dec_cnt_q;

    // start overrides everything; a coincident sample is dropped
    if (start) begin
      state_d   = S_FLUSH;
      wr_addr_d = '0;
      if (length == '0)          n_d = ONE_N;
      else if (length > DEPTH_N) n_d = DEPTH_N;
      else                       n_d = length;
      d_d = (decim == '0) ? ONE_D : decim;
    end else begin
      case (state_q)
        S_FLUSH: begin
          ram_we    = 1'b1;
          ram_wzero = 1'b1;
          acc_clear = (wr_addr_q == '0);
          wr_addr_d = wr_addr_q + ONE_A;
          if (wr_addr_q == '1) begin
            state_d    = S_FILL;
            fill_cnt_d = '0;
          end
        end
        S_FILL, S_RUN: begin
          if (din_valid) begin
            ram_we    = 1'b1;
            acc_en    = 1'b1;
            wr_addr_d = wr_addr_q + ONE_A;
            if (state_q == S_FILL) begin
              // Nth sample completes the window and restarts decimation at phase 0
              if (fill_cnt_q == n_q - ONE_N) begin
                state_d  = S_RUN;
                eligible = 1'b1;
                dec_base = '0;
              end else begin
                fill_cnt_d = fill_cnt_q + ONE_N;
              end
            end else begin
              eligible = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    if (eligible) begin
      dout_valid_d = (dec_base == '0);
      dec_cnt_d    = (dec_base == d_q - ONE_D) ? '0 : dec_base + ONE_D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_addr_q    <= '0;
      fill_cnt_q   <= '0;
      n_q          <= ONE_N;
      d_q          <= ONE_D;
      dec_cnt_q    <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      fill_cnt_q   <= fill_cnt_d;
      n_q          <= n_d;
      d_q          <= d_d;
      dec_cnt_q    <= dec_cnt_d;
      dout_valid_q <= dout_valid_d;
    end
  end

`ifdef BOXCAR_SEQ_CTRL_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (start) begin
      drop_cnt_d = din_valid ? 16'd1 : 16'd0;
    end else if (din_valid && (state_q == S_IDLE || state_q == S_FLUSH) &&
                 drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  // N=DEPTH gives rd_addr==wr_addr: the read-before-write RAM returns the oldest sample
  assign rd_addr    = (state_q == S_IDLE) ? '0 : wr_addr_q - n_q[ADDR_WIDTH-1:0];
  assign wr_addr    = wr_addr_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q == S_FLUSH) || (state_q == S_FILL);
  assign state      = state_q;

endmodule

// File: tb/tb_boxcar_seq_ctrl.sv
// Randomized bench for boxcar_seq_ctrl against a sample-count reference model.
module tb_boxcar_seq_ctrl;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   length = '0;
  logic [DW-1:0] decim = '0;
  logic          din_valid = 1'b0;
  logic          ram_we, ram_wzero, acc_clear, acc_en, dout_valid, busy;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [1:0]    state;
`ifdef BOXCAR_SEQ_CTRL_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  boxcar_seq_ctrl #(.ADDR_WIDTH(AW), .DECIM_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .length(length), .decim(decim),
    .din_valid(din_valid), .ram_we(ram_we), .ram_wzero(ram_wzero),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .acc_clear(acc_clear),
    .acc_en(acc_en), .dout_valid(dout_valid), .busy(busy), .state(state)
`ifdef BOXCAR_SEQ_CTRL_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: phase 0 idle, 1 flushing (m_fc cycles done), 2 active (m_s samples accepted)
  int m_ph, m_fc, m_s, m_n, m_d, m_drop;
  bit m_dv;
  int cfg_len, cfg_dec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_fc = 0; m_s = 0; m_n = 1; m_d = 1; m_drop = 0; m_dv = 1'b0;
  endtask

  // Called just after a rising edge; checks mid-cycle, then advances the model at the next edge.
  task automatic tick(input bit st, input bit dv);
    bit full;
    start = st;
    din_valid = dv;
    if (st) begin
      length = 5'(cfg_len);
      decim  = 8'(cfg_dec);
    end else begin
      length = 5'($urandom_range(0, 31));
      decim  = 8'($urandom_range(0, 255));
    end
    #3;
    chk("dout_valid", 32'(dout_valid), 32'(m_dv));
    case (m_ph)
      0: begin
        chk("idle_state", 32'(state), 0);
        chk("idle_busy", 32'(busy), 0);
        if (!st) begin
          chk("idle_ram_we", 32'(ram_we), 0);
          chk("idle_acc_en", 32'(acc_en), 0);
        end
      end
      1: begin
        chk("flush_state", 32'(state), 1);
        chk("flush_busy", 32'(busy), 1);
        chk("flush_wr_addr", 32'(wr_addr), 32'(m_fc));
        chk("flush_rd_addr", 32'(rd_addr), 32'((m_fc - m_n) & (DEPTH - 1)));
        if (!st) begin
          chk("flush_ram_we", 32'(ram_we), 1);
          chk("flush_ram_wzero", 32'(ram_wzero), 1);
          chk("flush_acc_clear", 32'(acc_clear), 32'(m_fc == 0));
          chk("flush_acc_en", 32'(acc_en), 0);
        end
      end
      default: begin
        full = (m_s >= m_n);
        chk("act_state", 32'(state), full ? 3 : 2);
        chk("act_busy", 32'(busy), 32'(!full));
        chk("act_wr_addr", 32'(wr_addr), 32'(m_s % DEPTH));
        chk("act_rd_addr", 32'(rd_addr), 32'((m_s - m_n) & (DEPTH - 1)));
        chk("act_ram_we", 32'(ram_we), 32'(dv && !st));
        chk("act_acc_en", 32'(acc_en), 32'(dv && !st));
        chk("act_ram_wzero", 32'(ram_wzero), 0);
        chk("act_acc_clear", 32'(acc_clear), 0);
      end
    endcase
`ifdef BOXCAR_SEQ_CTRL_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    @(posedge clk);
    if (st) begin
      m_ph = 1; m_fc = 0; m_dv = 1'b0;
      m_n = (cfg_len == 0) ? 1 : (cfg_len > DEPTH) ? DEPTH : cfg_len;
      m_d = (cfg_dec == 0) ? 1 : cfg_dec;
      m_drop = dv ? 1 : 0;
    end else if (m_ph == 0 || m_ph == 1) begin
      m_dv = 1'b0;
      if (dv && m_drop < 65535) m_drop++;
      if (m_ph == 1) begin
        m_fc++;
        if (m_fc == DEPTH) begin
          m_ph = 2; m_s = 0;
        end
      end
    end else if (dv) begin
      m_s++;
      m_dv = (m_s >= m_n) && (((m_s - m_n) % m_d) == 0);
    end else begin
      m_dv = 1'b0;
    end
    #1;
  endtask

  initial begin
    model_reset();
    cfg_len = 0; cfg_dec = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // IDLE ignores samples
    repeat (4) tick(1'b0, 1'b1);

    // N=5, D=1, continuous input, flush with din_valid held high
    cfg_len = 5; cfg_dec = 1;
    tick(1'b1, 1'b1);
    repeat (DEPTH + 30) tick(1'b0, 1'b1);

    // N=3, D=4, every other cycle
    cfg_len = 3; cfg_dec = 4;
    tick(1'b1, 1'b0);
    repeat (DEPTH) tick(1'b0, ($urandom_range(0, 1) == 1));
    for (int i = 0; i < 40; i++) tick(1'b0, (i % 2) == 0);

    // length=0 -> N=1, decim=0 -> D=1
    cfg_len = 0; cfg_dec = 0;
    tick(1'b1, 1'b1);
    repeat (DEPTH + 20) tick(1'b0, ($urandom_range(0, 1) == 1));

    // length=20 clamps to 16; enough samples to wrap wr_addr several times
    cfg_len = 20; cfg_dec = 3;
    tick(1'b1, 1'b0);
    repeat (DEPTH) tick(1'b0, 1'b0);
    repeat (70) tick(1'b0, ($urandom_range(0, 3) != 0));

    // restart mid-RUN with a coincident sample
    cfg_len = 7; cfg_dec = 2;
    tick(1'b1, 1'b1);
    repeat (DEPTH + 30) tick(1'b0, ($urandom_range(0, 1) == 1));

    // random configurations, including restarts mid-FLUSH and mid-FILL
    for (int r = 0; r < 6; r++) begin
      cfg_len = $urandom_range(0, 31);
      cfg_dec = $urandom_range(0, 6);
      tick(1'b1, ($urandom_range(0, 1) == 1));
      repeat ($urandom_range(5, 70)) tick(1'b0, ($urandom_range(0, 3) != 0));
    end

    // asynchronous reset mid-RUN
    cfg_len = 2; cfg_dec = 1;
    tick(1'b1, 1'b0);
    repeat (DEPTH + 6) tick(1'b0, 1'b1);
    din_valid = 1'b1;
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_wr_addr", 32'(wr_addr), 0);
    chk("arst_ram_we", 32'(ram_we), 0);
    chk("arst_dout_valid", 32'(dout_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (3) tick(1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
